vmem_arbiter: RTL and testbench
===============================

# vmem_arbiter

Single-port framebuffer arbiter that sits between the VGA scan-out path, a pixel writer (character renderer / UART-driven drawing logic) and one synchronous single-port 24-bit video RAM. VGA reads have strict priority and fixed latency; writer requests are buffered in a small FIFO and retired in cycles the VGA path leaves free. A built-in clear engine fills the whole framebuffer with one colour on request.

## Interface
- ADDR_W, 19, framebuffer address width; address is {h_addr[9:0], v_addr[8:0]}
- DATA_W, 24, pixel width (RGB888)
- WQ_DEPTH, 4, write FIFO depth; power of two, ≥2
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- vga_req  in  1  VGA needs pixel at vga_addr this cycle
- vga_addr  in  ADDR_W  VGA read address
- vga_data  out  DATA_W  read pixel, registered
- vga_valid  out  1  vga_data holds the pixel requested 2 cycles earlier
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  arbiter accepts; transfer when wr_valid & wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- clr_start  in  1  one-cycle pulse: clear whole framebuffer
- clr_color  in  DATA_W  fill colour, sampled on accepted clr_start
- clr_busy  out  1  clear pending or in progress
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  write (1) / read (0)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read
- stall_cnt  out  16  writer stall counter (see Configuration)

## Operation
- FSM states: RUN, DRAIN, CLEAR. Reset → RUN.
- Per-cycle port grant, combinational, priority: (1) vga_req → read vga_addr; (2) CLEAR and !vga_req → write clr_color at clr_ptr, clr_ptr+1; (3) RUN/DRAIN, FIFO non-empty, !vga_req → pop head, write it; else mem_en=0.
- Writer accepted only in RUN. wr_ready = (state==RUN) & !full. A push and a pop in the same cycle are both legal when not full; count is unchanged.
- clr_start accepted only in RUN (ignored otherwise); latches clr_color. FIFO empty → CLEAR; else → DRAIN. DRAIN → CLEAR when the FIFO goes empty. clr_ptr resets to 0 on entry to CLEAR.
- CLEAR → RUN after the write to address 2^ADDR_W−1; clr_ptr wraps to 0. clr_busy = (state != RUN).
- No read-after-write forwarding: a VGA read of an address still queued returns the old RAM value.
- Framebuffer never written with mem_we=1 while vga_req=1.

## Timing
- Reset values: vga_data=0, vga_valid=0, wr_ready=0 during reset and 1 the first cycle after; FIFO empty; clr_busy=0; clr_ptr=0; stall_cnt=0; mem_en=0, mem_we=0.
- Read latency: vga_req at cycle N → mem_rdata at N+1 → vga_data and vga_valid=1 at N+2. One result per cycle, fully pipelined, never stalled.
- Write latency: best case, a pixel accepted at N reaches RAM at N+1 (mem_we=1).
- Throughput: one RAM access per cycle. Writes starve indefinitely while vga_req stays high; the FIFO fills and wr_ready drops.
- Clear of 2^19 pixels needs 524288 free cycles, blanking cycles only under continuous scan-out.
- rst mid-clear or mid-drain: immediate return to RUN; FIFO flushed; queued pixels are lost.

## Configuration
- VMEM_ARB_STATS_EN defined: stall_cnt increments every cycle with wr_valid & !wr_ready, saturates at 16'hFFFF, and clears on rst.
- Not defined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Reset, then vga_req=1 with addr 0x00005 (RAM holds 0x123456): vga_valid=1 and vga_data=0x123456 exactly 2 cycles later.
- vga_req held high and 5 writes offered: 4 accepted, wr_ready=0 on the 5th, mem_we never 1; drop vga_req → 4 writes retire on consecutive cycles in order.
- Write 0xFF0000 to 0x00100 while vga_req=0, then read 0x00100: vga_data=0xFF0000.
- clr_start with 2 pixels queued, clr_color=0x0000FF: DRAIN writes the 2 pixels first, then CLEAR; with vga_req=0, clr_busy falls 524288 cycles after entering CLEAR; spot-read addresses 0, 0x3FFFF and 0x7FFFF = 0x0000FF.
- rst asserted mid-CLEAR: next cycle state RUN, clr_busy=0, FIFO empty, wr_ready=1.
- With VMEM_ARB_STATS_EN: 10 stalled wr_valid cycles → stall_cnt=10; without it, stall_cnt=0.

Source files
------------

// File: rtl/vmem_arbiter_if.sv
// Bundle of the VGA read, pixel-writer, clear-control and RAM port signals around vmem_arbiter.
// slave = arbiter side, master = surrounding logic (scan-out, writer, RAM).
interface vmem_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       stall_cnt;

    modport slave (
        input  vga_req, vga_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        output vga_data, vga_valid, wr_ready, clr_busy,
               mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );

    modport master (
        output vga_req, vga_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, mem_rdata,
        input  vga_data, vga_valid, wr_ready, clr_busy,
               mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port framebuffer arbiter: VGA reads first, queued writer pixels and the clear engine fill idle cycles.
// Optional writer stall counter built only when VMEM_ARB_STATS_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal operation, writer accepted, clr_start accepted
// ST_DRAIN | clear requested, retiring queued pixels before the fill starts
// ST_CLEAR | filling every address with clr_color in free cycles
module vmem_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 24,
    parameter int WQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    vmem_arbiter_if.slave  bus
);
    localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
    logic [ADDR_W-1:0] wq_addr_d [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_d [WQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;

    logic              rd_pend_q, rd_pend_d;
    logic              vga_valid_q, vga_valid_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;

    logic              wq_empty, wq_full;
    logic              wr_ready;
    logic              push, pop;
    logic              grant_rd, grant_clr;
    logic              clr_accept, clr_last;

    assign wq_empty   = (cnt_q == '0);
    assign wq_full    = (cnt_q == FULL_CNT);
    // Held low through reset so the writer never sees a ready during it.
    assign wr_ready   = !rst && (state_q == ST_RUN) && !wq_full;
    assign push       = bus.wr_valid && wr_ready;
    assign clr_accept = !rst && (state_q == ST_RUN) && bus.clr_start;
    assign clr_last   = grant_clr && (clr_ptr_q == '1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cnt_d lets a same-cycle push or final pop steer the decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (clr_accept) begin
                    state_d = (cnt_d == '0) ? ST_CLEAR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_last) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic: per-cycle RAM port grant, VGA strictly first
    always_comb begin
        grant_rd      = 1'b0;
        grant_clr     = 1'b0;
        pop           = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!rst) begin
            if (bus.vga_req) begin
                grant_rd     = 1'b1;
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.vga_addr;
            end else if (state_q == ST_CLEAR) begin
                grant_clr     = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = clr_ptr_q;
                bus.mem_wdata = clr_color_q;
            end else if (!wq_empty) begin
                pop           = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = wq_addr_q[rd_ptr_q];
                bus.mem_wdata = wq_data_q[rd_ptr_q];
            end
        end
    end

    // Write FIFO bookkeeping; pointers wrap naturally because depth is a power of two
    always_comb begin
        wq_addr_d = wq_addr_q;
        wq_data_d = wq_data_q;
        if (push) begin
            wq_addr_d[wr_ptr_q] = bus.wr_addr;
            wq_data_d[wr_ptr_q] = bus.wr_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        clr_color_d = clr_accept ? bus.clr_color : clr_color_q;
        clr_ptr_d   = clr_ptr_q;
        if ((state_q != ST_CLEAR) && (state_d == ST_CLEAR)) begin
            clr_ptr_d = '0;
        end else if (grant_clr) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
        end
    end

    // Read return pipeline: RAM data arrives one cycle after the grant, registered once more
    always_comb begin
        rd_pend_d   = grant_rd;
        vga_valid_d = rd_pend_q;
        vga_data_d  = rd_pend_q ? bus.mem_rdata : vga_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            clr_ptr_q   <= '0;
            clr_color_q <= '0;
            rd_pend_q   <= 1'b0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
            rd_pend_q   <= rd_pend_d;
            vga_valid_q <= vga_valid_d;
            vga_data_q  <= vga_data_d;
        end
    end

    // Queue storage needs no reset: the count alone says which entries are live
    always_ff @(posedge clk) begin
        wq_addr_q <= wq_addr_d;
        wq_data_q <= wq_data_d;
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.clr_busy  = (state_q != ST_RUN);
    assign bus.vga_valid = vga_valid_q;
    assign bus.vga_data  = vga_data_q;

`ifdef VMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a 10-bit framebuffer so a full clear stays short.
// Holds a behavioural single-port RAM; expected values are hand-computed constants.
module tb_vmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 24;
    localparam int LAST_ADDR = (1 << AW) - 1;
`ifdef VMEM_ARB_STATS_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic clk;
    logic rst;
    logic ram_init;
    int   checks;
    int   errors;
    int   viol;
    int   k;

    vmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:LAST_ADDR];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i <= LAST_ADDR; i++) ram[i] <= '0;
            ram[5] <= 24'h123456;
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Any framebuffer write while the VGA path is requesting is a priority violation
    always @(negedge clk) begin
        if (!rst && bus.mem_we && bus.vga_req) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0; viol = 0; k = 0;
        rst = 1'b1; ram_init = 1'b1;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 1'b0; bus.clr_color = '0;
        repeat (3) tick();
        ram_init = 1'b0;

        // reset values
        check("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        check("rst_mem_en",    32'(bus.mem_en),    32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
        check("rst_vga_data",  32'(bus.vga_data),  32'd0);
        check("rst_clr_busy",  32'(bus.clr_busy),  32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // read latency: request at N, data at N+2
        bus.vga_req = 1'b1; bus.vga_addr = AW'(5);
        #1;
        check("rd_mem_en",   32'(bus.mem_en),   32'd1);
        check("rd_mem_we",   32'(bus.mem_we),   32'd0);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'd5);
        tick();
        bus.vga_req = 1'b0;
        #1;
        check("rd_valid_n1", 32'(bus.vga_valid), 32'd0);
        tick();
        check("rd_valid_n2", 32'(bus.vga_valid), 32'd1);
        check("rd_data_n2",  32'(bus.vga_data),  32'h123456);
        tick();
        check("rd_valid_n3", 32'(bus.vga_valid), 32'd0);

        // writes starved under continuous VGA requests, then retire in order
        bus.vga_req = 1'b1; bus.vga_addr = '0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(16 + i);
            bus.wr_data  = DW'(32'hA0000 + i);
            #1;
            check($sformatf("starve_ready_%0d", i), 32'(bus.wr_ready), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_we_%0d", i),    32'(bus.mem_we),   32'd0);
            tick();
        end
        bus.wr_valid = 1'b0; bus.vga_req = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("retire_we_%0d", j),    32'(bus.mem_we),    32'd1);
            check($sformatf("retire_addr_%0d", j),  32'(bus.mem_addr),  32'(16 + j));
            check($sformatf("retire_wdata_%0d", j), 32'(bus.mem_wdata), 32'hA0000 + 32'(j));
            tick();
        end
        check("retire_idle", 32'(bus.mem_en), 32'd0);

        // best-case write latency and read-back
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(12'h100); bus.wr_data = 24'hFF0000;
        #1;
        check("wr1_ready", 32'(bus.wr_ready), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("wr1_we",    32'(bus.mem_we),    32'd1);
        check("wr1_addr",  32'(bus.mem_addr),  32'h100);
        check("wr1_wdata", 32'(bus.mem_wdata), 32'hFF0000);
        tick();
        bus.vga_req = 1'b1; bus.vga_addr = AW'(12'h100);
        tick();
        bus.vga_req = 1'b0;
        tick();
        check("wr1_readback", 32'(bus.vga_data), 32'hFF0000);

        // clear with two pixels queued: DRAIN first, then CLEAR
        bus.vga_req = 1'b1; bus.vga_addr = '0;
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(32); bus.wr_data = 24'h111111;
        tick();
        bus.wr_addr = AW'(33); bus.wr_data = 24'h222222;
        tick();
        bus.wr_valid = 1'b0;
        bus.clr_start = 1'b1; bus.clr_color = 24'h0000FF;
        tick();
        bus.clr_start = 1'b0; bus.clr_color = 24'h00FF00;
        #1;
        check("drain_busy",  32'(bus.clr_busy), 32'd1);
        check("drain_ready", 32'(bus.wr_ready), 32'd0);
        check("drain_hold",  32'(bus.mem_we),   32'd0);
        bus.vga_req = 1'b0;
        #1;
        check("drain0_addr",  32'(bus.mem_addr),  32'd32);
        check("drain0_wdata", 32'(bus.mem_wdata), 32'h111111);
        tick();
        check("drain1_addr",  32'(bus.mem_addr),  32'd33);
        check("drain1_wdata", 32'(bus.mem_wdata), 32'h222222);
        tick();
        check("clear0_we",    32'(bus.mem_we),    32'd1);
        check("clear0_addr",  32'(bus.mem_addr),  32'd0);
        check("clear0_wdata", 32'(bus.mem_wdata), 32'h0000FF);
        k = 0;
        while (bus.clr_busy && k < 3000) begin
            tick();
            k++;
        end
        check("clear_cycles",    32'(k),             32'(LAST_ADDR + 1));
        check("clear_done_rdy",  32'(bus.wr_ready),  32'd1);
        check("clear_done_idle", 32'(bus.mem_en),    32'd0);

        // pipelined spot reads after the clear
        bus.vga_req = 1'b1; bus.vga_addr = AW'(0);
        tick();
        bus.vga_addr = AW'(LAST_ADDR / 2);
        tick();
        bus.vga_addr = AW'(LAST_ADDR);
        check("spot_lo_valid", 32'(bus.vga_valid), 32'd1);
        check("spot_lo",       32'(bus.vga_data),  32'h0000FF);
        tick();
        bus.vga_req = 1'b0;
        check("spot_mid", 32'(bus.vga_data), 32'h0000FF);
        tick();
        check("spot_hi",  32'(bus.vga_data), 32'h0000FF);

        // no forwarding: a queued write is invisible to a concurrent read
        bus.vga_req = 1'b1; bus.vga_addr = AW'(48);
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(48); bus.wr_data = 24'hABCDEF;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        check("nofwd_old", 32'(bus.vga_data), 32'h0000FF);
        bus.vga_req = 1'b0;
        #1;
        check("nofwd_we",    32'(bus.mem_we),    32'd1);
        check("nofwd_wdata", 32'(bus.mem_wdata), 32'hABCDEF);
        tick();
        bus.vga_req = 1'b1;
        tick();
        bus.vga_req = 1'b0;
        tick();
        check("nofwd_new", 32'(bus.vga_data), 32'hABCDEF);

        // reset in the middle of a clear
        bus.clr_start = 1'b1; bus.clr_color = 24'h00FF00;
        tick();
        bus.clr_start = 1'b0;
        check("midclr_busy", 32'(bus.clr_busy), 32'd1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midclr_rst_busy",  32'(bus.clr_busy), 32'd0);
        check("midclr_rst_ready", 32'(bus.wr_ready), 32'd1);
        check("midclr_rst_idle",  32'(bus.mem_en),   32'd0);

        // reset in the middle of a drain flushes the queue
        bus.vga_req = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(64); bus.wr_data = 24'h333333;
        repeat (2) tick();
        bus.wr_valid = 1'b0; bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        check("middrain_busy", 32'(bus.clr_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.vga_req = 1'b0;
        #1;
        check("middrain_rst_busy", 32'(bus.clr_busy), 32'd0);
        check("middrain_flushed",  32'(bus.mem_en),   32'd0);

        // writer stall counter
        bus.vga_req = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(80); bus.wr_data = 24'h444444;
        repeat (4) tick();
        repeat (10) tick();
        bus.wr_valid = 1'b0;
        #1;
        check("stall_ready", 32'(bus.wr_ready),  32'd0);
        check("stall_cnt",   32'(bus.stall_cnt), 32'(STALL_EXP));
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.vga_req = 1'b0;
        #1;
        check("stall_cnt_rst", 32'(bus.stall_cnt), 32'd0);
        tick();

        check("no_write_under_vga", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
